// File: rtl/design_sel_sequencer_pkg.sv
// Shared types and default sizing for the design-select sequencer.
package design_sel_pkg;

    typedef enum logic [2:0] {
        POR,
        RUN,
        DEBOUNCE,
        PRE_RST,
        SWITCH,
        POST_RST
    } seq_state_t;

    localparam int unsigned SEL_W_DEF         = 6;
    localparam int unsigned STABLE_CYCLES_DEF = 16;
    localparam int unsigned RESET_CYCLES_DEF  = 8;

endpackage

// File: rtl/design_sel_sequencer_pin_sync.sv
// Multi-stage synchronizer for raw asynchronous pins; all stages clear on reset.
module pin_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/design_sel_sequencer.sv
// Debounces the design select and wraps every accepted change in a
// reset-before / switch / reset-after sequence for the design mux.
module design_sel_sequencer
    import design_sel_pkg::*;
#(
    parameter int unsigned SEL_W         = SEL_W_DEF,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned RESET_CYCLES  = RESET_CYCLES_DEF,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [SEL_W-1:0] sel_pin,
    input  logic             rst_pin,
    input  logic             hold_pin,
    input  logic             la_override,
    input  logic [SEL_W-1:0] sel_la,
    output logic [SEL_W-1:0] des_sel,
    output logic             des_reset,
    output logic             hold_if_not_sel,
    output logic             busy,
    output logic [7:0]       switch_count
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SEL_W-1:0] sel_sync;
    logic             rst_sync;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] pend;
    logic [CNT_W-1:0] cnt;
    seq_state_t       state;

    pin_sync #(.WIDTH(SEL_W), .STAGES(SYNC_STAGES)) u_sel_sync (
        .clock(clock), .reset_n(reset_n), .d(sel_pin), .q(sel_sync)
    );
    pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rst_sync (
        .clock(clock), .reset_n(reset_n), .d(rst_pin), .q(rst_sync)
    );
    pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_hold_sync (
        .clock(clock), .reset_n(reset_n), .d(hold_pin), .q(hold_if_not_sel)
    );

    assign cand = la_override ? sel_la : sel_sync;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= POR;
            cnt          <= '0;
            pend         <= '0;
            des_sel      <= '0;
            des_reset    <= 1'b1;
            busy         <= 1'b1;
            switch_count <= '0;
        end else begin
            unique case (state)
                POR: begin
                    des_reset <= 1'b1;
                    if (cnt == RST_LAST) begin
                        cnt       <= '0;
                        des_sel   <= cand;
                        des_reset <= rst_sync;
                        busy      <= 1'b0;
                        state     <= RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    des_reset <= rst_sync;
                    if (cand != des_sel) begin
                        pend  <= cand;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    des_reset <= rst_sync;
                    if (cand != pend) begin
                        pend <= cand;
                        cnt  <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        cnt <= '0;
                        if (pend == des_sel) begin
                            busy  <= 1'b0;
                            state <= RUN;
                        end else begin
                            des_reset <= 1'b1;
                            state     <= PRE_RST;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRE_RST: begin
                    des_reset <= 1'b1;
                    // Select and count are loaded on PRE_RST exit so they are visible during the SWITCH cycle.
                    if (cnt == RST_LAST) begin
                        cnt          <= '0;
                        des_sel      <= pend;
                        switch_count <= switch_count + 8'd1;
                        state        <= SWITCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SWITCH: begin
                    des_reset <= 1'b1;
                    cnt       <= '0;
                    state     <= POST_RST;
                end
                POST_RST: begin
                    des_reset <= 1'b1;
                    if (cnt == RST_LAST) begin
                        cnt       <= '0;
                        des_reset <= rst_sync;
                        busy      <= 1'b0;
                        state     <= RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt       <= '0;
                    des_reset <= 1'b1;
                    busy      <= 1'b1;
                    state     <= POR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_design_sel_sequencer.sv
// Self-checking bench for design_sel_sequencer: hand sequences for timing
// corners plus a table of select/override vectors checked through a queue.
module tb_design_sel_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 16;
    localparam int RSTC   = 8;
    localparam int SETTLE = SYNC + 1 + STABLE;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] sel_pin = 6'd5;
    logic       rst_pin = 1'b0;
    logic       hold_pin = 1'b0;
    logic       la_override = 1'b0;
    logic [5:0] sel_la = 6'd0;
    logic [5:0] des_sel;
    logic       des_reset;
    logic       hold_if_not_sel;
    logic       busy;
    logic [7:0] switch_count;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic       ovr;
        logic [5:0] pin;
        logic [5:0] la;
        logic [5:0] exp_sel;
        logic [7:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [5:0] sel;
        logic [7:0] cnt;
    } exp_t;

    vec_t vecs [7];
    exp_t sbq [$];

    always #5 clock = ~clock;

    design_sel_sequencer #(
        .SEL_W(6), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
        .RESET_CYCLES(RSTC), .CNT_W(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sel_pin(sel_pin), .rst_pin(rst_pin),
        .hold_pin(hold_pin), .la_override(la_override), .sel_la(sel_la),
        .des_sel(des_sel), .des_reset(des_reset), .hold_if_not_sel(hold_if_not_sel),
        .busy(busy), .switch_count(switch_count)
    );

    task automatic chk(input string name, input int act, input int expv);
        nvec++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Select must never move unless the designs were already held in reset.
    logic [5:0] prev_sel;
    logic       prev_rst;
    logic       prev_valid = 1'b0;
    always @(negedge clock) begin
        if (prev_valid && des_sel !== prev_sel)
            chk("sel_moved_outside_reset", int'(prev_rst), 1);
        prev_sel   <= des_sel;
        prev_rst   <= des_reset;
        prev_valid <= 1'b1;
    end

    task automatic por_wait(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 100);
        chk({tag, "_por_len"}, n, RSTC);
    endtask

    task automatic measure_switch(input logic [5:0] old_sel, input logic [5:0] new_sel,
                                  output int first_hi, output int hi, output int old_hi,
                                  output int new_hi);
        int n;
        first_hi = -1; hi = 0; old_hi = 0; new_hi = 0;
        for (n = 1; n <= 120; n++) begin
            tick();
            if (des_reset) begin
                if (first_hi < 0) first_hi = n;
                hi++;
                if (des_sel == old_sel) old_hi++;
                if (des_sel == new_sel) new_hi++;
            end else if (hi > 0) begin
                break;
            end
        end
        if (n > 120) chk("switch_timeout", 1, 0);
    endtask

    initial begin
        int fh, hi, ohi, nhi, n;
        logic dr_seen, busy_seen;

        vecs[0] = '{1'b1, 6'd9,  6'd40, 6'd40, 8'd3};
        vecs[1] = '{1'b0, 6'd9,  6'd40, 6'd9,  8'd4};
        vecs[2] = '{1'b1, 6'd9,  6'd9,  6'd9,  8'd4};
        vecs[3] = '{1'b0, 6'd63, 6'd9,  6'd63, 8'd5};
        vecs[4] = '{1'b0, 6'd0,  6'd9,  6'd0,  8'd6};
        vecs[5] = '{1'b1, 6'd0,  6'd63, 6'd63, 8'd7};
        vecs[6] = '{1'b0, 6'd63, 6'd0,  6'd63, 8'd7};

        // Power-on reset
        repeat (3) tick();
        chk("rst_des_sel", des_sel, 0);
        chk("rst_des_reset", des_reset, 1);
        chk("rst_busy", busy, 1);
        chk("rst_switch_count", switch_count, 0);
        chk("rst_hold", hold_if_not_sel, 0);
        reset_n = 1'b1;
        por_wait("init");
        chk("por_des_sel", des_sel, 5);
        chk("por_des_reset", des_reset, 0);
        chk("por_switch_count", switch_count, 0);

        // Clean switch 5 -> 12
        sel_pin = 6'd12;
        measure_switch(6'd5, 6'd12, fh, hi, ohi, nhi);
        chk("clean_first_reset", fh, SETTLE);
        chk("clean_reset_len", hi, 2 * RSTC + 1);
        chk("clean_old_sel_cycles", ohi, RSTC);
        chk("clean_new_sel_cycles", nhi, RSTC + 1);
        chk("clean_des_sel", des_sel, 12);
        chk("clean_switch_count", switch_count, 1);
        chk("clean_busy", busy, 0);

        // Glitch rejection
        sel_pin = 6'd3;
        dr_seen = 1'b0; busy_seen = 1'b0;
        for (int i = 0; i < 44; i++) begin
            if (i == 4) sel_pin = 6'd12;
            tick();
            if (des_reset) dr_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        chk("glitch_reset_seen", dr_seen, 0);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_end", busy, 0);
        chk("glitch_des_sel", des_sel, 12);
        chk("glitch_switch_count", switch_count, 1);

        // Debounce restart: toggling faster than the stable window
        dr_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel_pin = (i % 2 == 0) ? 6'd7 : 6'd9;
            repeat (10) begin
                tick();
                if (des_reset) dr_seen = 1'b1;
            end
        end
        chk("restart_no_early_reset", dr_seen, 0);
        chk("restart_count_mid", switch_count, 1);
        sel_pin = 6'd9;
        measure_switch(6'd12, 6'd9, fh, hi, ohi, nhi);
        chk("restart_first_reset", fh, SETTLE);
        chk("restart_reset_len", hi, 2 * RSTC + 1);
        chk("restart_des_sel", des_sel, 9);
        chk("restart_switch_count", switch_count, 2);

        // Override / select table
        foreach (vecs[i]) begin
            exp_t e;
            e.sel = vecs[i].exp_sel;
            e.cnt = vecs[i].exp_cnt;
            sbq.push_back(e);
            la_override = vecs[i].ovr;
            sel_pin     = vecs[i].pin;
            sel_la      = vecs[i].la;
            repeat (60) tick();
            e = sbq.pop_front();
            chk($sformatf("vec%0d_des_sel", i), des_sel, e.sel);
            chk($sformatf("vec%0d_switch_count", i), switch_count, e.cnt);
            chk($sformatf("vec%0d_des_reset", i), des_reset, 0);
            chk($sformatf("vec%0d_busy", i), busy, 0);
        end

        // Reset pin passthrough in RUN
        rst_pin = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!des_reset && n < 20);
        chk("rstpin_latency", n, SYNC + 1);
        chk("rstpin_des_sel", des_sel, 63);
        chk("rstpin_busy", busy, 0);
        rst_pin = 1'b0;
        repeat (SYNC + 1) tick();
        chk("rstpin_release", des_reset, 0);

        // Hold pin synchronizer
        hold_pin = 1'b1;
        tick();
        chk("hold_stage1", hold_if_not_sel, 0);
        tick();
        chk("hold_stage2", hold_if_not_sel, 1);

        // Reset in the middle of POST_RST
        sel_pin = 6'd21;
        n = 0;
        do begin
            tick();
            n++;
        end while (des_sel != 6'd21 && n < 100);
        chk("mid_reached_switch", int'(des_sel), 21);
        repeat (3) tick();
        chk("mid_in_post_reset", des_reset, 1);
        reset_n = 1'b0;
        tick();
        chk("mid_des_sel", des_sel, 0);
        chk("mid_des_reset", des_reset, 1);
        chk("mid_switch_count", switch_count, 0);
        chk("mid_busy", busy, 1);
        reset_n = 1'b1;
        por_wait("mid");
        chk("mid_por_des_sel", des_sel, 21);
        chk("mid_por_des_reset", des_reset, 0);
        chk("mid_por_switch_count", switch_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
